// File: rtl/addsub_arb_pkg.sv
// Shared constants for the add/subtract arbiter slice.
//   state_t : arbiter FSM state encoding (IDLE, EXEC, RESP)
//   OP_ADD / OP_SUB : operation select encoding used on reqX_op
package addsub_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_nbit.sv
// Combinational signed adder/subtractor with one bit of growth.
//   a, b   : n-bit two's-complement operands
//   op     : OP_ADD -> a+b, OP_SUB -> a-b
//   result : n+1-bit signed result; cannot overflow
module addsub_nbit
   import addsub_arb_pkg::*;
#(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         op,
   output logic [n:0]   result
);

   logic signed [n:0] a_ext;
   logic signed [n:0] b_ext;

   // Sign-extend first so the extra bit absorbs any carry/borrow.
   assign a_ext  = signed'({a[n-1], a});
   assign b_ext  = signed'({b[n-1], b});
   assign result = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/addsub_arb.sv
// Two-requester round-robin arbiter in front of a shared add/subtract unit.
// One operation is in flight at a time: IDLE accepts, EXEC computes and
// registers the result, RESP presents it until the consumer takes it.
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqX_valid/ready       : requester handshake (ready only in IDLE)
//   reqX_a, reqX_b, reqX_op: operands and operation (0 add, 1 subtract)
//   res_valid/ready        : result handshake
//   res_data, res_id       : n+1-bit signed result and its requester index
//   busy                   : high whenever the FSM is not in IDLE
module addsub_arb
   import addsub_arb_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [n-1:0] req0_a,
   input  logic [n-1:0] req0_b,
   input  logic [n-1:0] req1_a,
   input  logic [n-1:0] req1_b,
   input  logic         req0_op,
   input  logic         req1_op,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [n:0]   res_data,
   output logic         res_id,
   output logic         busy
);

   state_t       state;
   state_t       state_nxt;
   logic         rr;
   logic         gnt_v;
   logic         gnt_id;
   logic [n-1:0] a_q;
   logic [n-1:0] b_q;
   logic         op_q;
   logic         id_q;
   logic [n:0]   sum;

   // Next state, grant and ready decode
   always_comb begin
      state_nxt  = state;
      gnt_v      = 1'b0;
      gnt_id     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               gnt_v = 1'b1;
               // A lone request wins outright; contention goes to rr.
               gnt_id     = (req0_valid && req1_valid) ? rr : req1_valid;
               req0_ready = ~gnt_id;
               req1_ready = gnt_id;
               state_nxt  = S_EXEC;
            end
         end
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, pointer and operand capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         rr    <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= 1'b0;
         id_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (gnt_v) begin
            rr   <= ~gnt_id;
            a_q  <= gnt_id ? req1_a  : req0_a;
            b_q  <= gnt_id ? req1_b  : req0_b;
            op_q <= gnt_id ? req1_op : req0_op;
            id_q <= gnt_id;
         end
      end
   end

   addsub_nbit #(.n(n)) u_addsub (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (sum)
   );

   // Result register: loaded only in EXEC, so it holds steady through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data <= '0;
         res_id   <= 1'b0;
      end else if (state == S_EXEC) begin
         res_data <= sum;
         res_id   <= id_q;
      end
   end

   assign res_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_addsub_arb.sv
module tb_addsub_arb;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_op = 1'b0, req1_op = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [N:0]   res_data;
   logic         res_id;
   logic         busy;

   always #5 clk = ~clk;

   addsub_arb #(.n(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req0_op    (req0_op),
      .req1_op    (req1_op),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .busy       (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one operation outstanding, its age in cycles since
   // acceptance, its expected value, and whose turn it is on contention.
   bit m_busy = 1'b0;
   int m_age  = 0;
   int m_exp  = 0;
   int m_id   = 0;
   int m_rr   = 0;

   int got_data[$];
   int got_id[$];
   int grants[$];

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Called just after a rising edge with inputs already set.
   task automatic step();
      bit gv;
      int gid;
      bit erv;
      bit cons;
      int ea, eb, eop, ev;
      @(negedge clk);
      gv  = 1'b0;
      gid = 0;
      ev  = 0;
      if (!m_busy && (req0_valid || req1_valid)) begin
         gv  = 1'b1;
         gid = (req0_valid && req1_valid) ? m_rr : (req1_valid ? 1 : 0);
      end
      erv = m_busy && (m_age >= 2);
      chk("req0_ready", int'(req0_ready), int'(gv && gid == 0));
      chk("req1_ready", int'(req1_ready), int'(gv && gid == 1));
      chk("busy",       int'(busy),       int'(m_busy));
      chk("res_valid",  int'(res_valid),  int'(erv));
      if (erv) begin
         chk("res_data", $signed(res_data), m_exp);
         chk("res_id",   int'(res_id),      m_id);
      end
      cons = erv && res_ready;
      if (cons) begin
         got_data.push_back($signed(res_data));
         got_id.push_back(int'(res_id));
      end
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (gv) begin
         ea  = (gid == 1) ? $signed(req1_a) : $signed(req0_a);
         eb  = (gid == 1) ? $signed(req1_b) : $signed(req0_b);
         eop = (gid == 1) ? int'(req1_op) : int'(req0_op);
         ev  = (eop == 1) ? (ea - eb) : (ea + eb);
      end
      @(posedge clk);
      if (gv) begin
         m_busy = 1'b1;
         m_age  = 1;
         m_exp  = ev;
         m_id   = gid;
         m_rr   = 1 - gid;
      end else if (m_busy) begin
         if (cons) m_busy = 1'b0;
         else      m_age++;
      end
      #1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Asynchronous reset applied away from the clock edge.
   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_busy",      int'(busy),       0);
      chk("rst_res_valid", int'(res_valid),  0);
      chk("rst_res_data",  int'(res_data),   0);
      chk("rst_res_id",    int'(res_id),     0);
      chk("rst_req0_rdy",  int'(req0_ready), 0);
      chk("rst_req1_rdy",  int'(req1_ready), 0);
      m_busy = 1'b0;
      m_age  = 0;
      m_rr   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_operands();
      req0_a  = N'($urandom);
      req0_b  = N'($urandom);
      req1_a  = N'($urandom);
      req1_b  = N'($urandom);
      req0_op = 1'($urandom);
      req1_op = 1'($urandom);
   endtask

   initial begin
      #2;
      do_reset();

      // Single add from requester 0
      got_data.delete(); got_id.delete();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd3; req0_op = 1'b0;
      step();
      req0_valid = 1'b0; req0_a = 8'd99;
      run(3);
      chk("r030_count", got_data.size(), 1);
      if (got_data.size() >= 1) begin
         chk("r030_data", got_data[0], 13);
         chk("r030_id",   got_id[0],   0);
      end

      // Single subtract from requester 1, then contention goes to 0
      got_data.delete(); got_id.delete();
      req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'hFE; req1_op = 1'b1;
      step();
      req1_valid = 1'b0;
      run(2);
      chk("r031_count", got_data.size(), 1);
      if (got_data.size() >= 1) begin
         chk("r031_data", got_data[0], 7);
         chk("r031_id",   got_id[0],   1);
      end
      grants.delete();
      rand_operands();
      req0_valid = 1'b1; req1_valid = 1'b1;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      run(2);
      chk("r031_grant_n", grants.size(), 1);
      if (grants.size() >= 1) chk("r031_grant", grants[0], 0);

      // Both valid right after reset, extreme operands
      do_reset();
      got_data.delete(); got_id.delete();
      req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'hFF; req0_op = 1'b1;
      req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h01; req1_op = 1'b1;
      step();
      req0_valid = 1'b0;
      run(3);
      req1_valid = 1'b0;
      run(2);
      chk("r032_count", got_data.size(), 2);
      if (got_data.size() >= 2) begin
         chk("r032_data0", got_data[0], 128);
         chk("r032_id0",   got_id[0],   0);
         chk("r032_data1", got_data[1], -129);
         chk("r032_id1",   got_id[1],   1);
      end

      // Back-pressure in RESP
      got_data.delete(); got_id.delete();
      req0_valid = 1'b1; req0_a = 8'hFB; req0_b = 8'hFB; req0_op = 1'b1;
      step();
      req0_valid = 1'b0;
      res_ready = 1'b0;
      run(4);
      res_ready = 1'b1;
      run(2);
      chk("r033_count", got_data.size(), 1);
      if (got_data.size() >= 1) chk("r033_data", got_data[0], 0);

      // Reset while in EXEC discards the operation
      got_data.delete(); got_id.delete();
      rand_operands();
      req0_valid = 1'b1;
      step();
      do_reset();
      run(5);
      chk("r034_none", got_data.size(), 0);

      // Continuous contention alternates grants
      grants.delete(); got_data.delete();
      res_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         rand_operands();
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("r035_grants", grants.size(), 6);
      chk("r035_results", got_data.size(), 6);
      for (int i = 0; i < grants.size(); i++) chk("r035_alt", grants[i], i % 2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_operands();
         req0_valid = 1'($urandom);
         req1_valid = 1'($urandom);
         res_ready  = ($urandom_range(3, 0) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
